io_input_responder: RTL and testbench

Memory-mapped input peripheral answering processor load/store accesses for the pushbuttons and slide switches. It holds a data register and a control/status register for each device. Each control register has ready and overrun flags, so software can poll for changes instead of re-reading raw inputs. It sits on the device side of the processor's I/O address decode and replaces the bare KEY/SW sample registers, including their mux into the load-data path.

---
 rtl/io_input_responder.sv | 125 ++++++++++++
 tb/tb_io_input_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_responder.sv
// io_input_responder: memory-mapped pushbutton/switch registers with
// synchronizers, switch debounce and per-device ready/overrun status.
module io_input_responder #(
    parameter int DBITS = 32,
    parameter logic [DBITS-1:0] ADDR_KDATA = DBITS'(32'hF0000010),
    parameter logic [DBITS-1:0] ADDR_SDATA = DBITS'(32'hF0000014),
    parameter logic [DBITS-1:0] ADDR_KCTRL = DBITS'(32'hF0000110),
    parameter logic [DBITS-1:0] ADDR_SCTRL = DBITS'(32'hF0000114),
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic             rdEn,
    input  logic             wrEn,
    input  logic [DBITS-1:0] wrData,
    output logic             rdHit,
    output logic [DBITS-1:0] rdData
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DLAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    ks1, ks2, kData;
    logic [9:0]    ss1, ss2, sData;
    logic [CW-1:0] dcnt;
    logic          kRdy, kOvr, sRdy, sOvr;
    logic          live, active;
    logic          selKD, selSD, selKC, selSC;
    logic          kRd, sRd, kClr, sClr;
    logic          kChg, sDiff, sChg;
    logic          unusedWr;

    // Bus is held off for the first cycle after reset.
    assign active = live & ~reset;

    assign selKD = addr == ADDR_KDATA;
    assign selSD = addr == ADDR_SDATA;
    assign selKC = addr == ADDR_KCTRL;
    assign selSC = addr == ADDR_SCTRL;

    assign rdHit = active & rdEn & (selKD | selSD | selKC | selSC);

    assign kRd  = active & rdEn & selKD;
    assign sRd  = active & rdEn & selSD;
    assign kClr = active & wrEn & selKC & ~wrData[2];
    assign sClr = active & wrEn & selSC & ~wrData[2];

    assign kChg  = ks2 != kData;
    assign sDiff = ss2 != sData;
    assign sChg  = sDiff && (dcnt == DLAST);

    assign unusedWr = ^{wrData[DBITS-1:3], wrData[1:0]};

    always_comb begin
        rdData = '0;
        if (rdHit) begin
            unique case (1'b1)
                selKD: rdData[3:0] = kData;
                selSD: rdData[9:0] = sData;
                selKC: begin
                    rdData[0] = kRdy;
                    rdData[2] = kOvr;
                end
                selSC: begin
                    rdData[0] = sRdy;
                    rdData[2] = sOvr;
                end
                default: ;
            endcase
        end
    end

    // A pending overrun set wins over a same-cycle software clear.
    function automatic logic [1:0] nextFlags(
        input logic rdy,
        input logic ovr,
        input logic chg,
        input logic rd,
        input logic clr
    );
        logic r, o;
        r = rdy;
        o = ovr & ~clr;
        if (chg) begin
            if (!rdy) r = 1'b1;
            else if (!rd) o = 1'b1;
        end else if (rd) begin
            r = 1'b0;
        end
        return {r, o};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            live  <= 1'b0;
            ks1   <= '0;
            ks2   <= '0;
            ss1   <= '0;
            ss2   <= '0;
            kData <= '0;
            sData <= '0;
            dcnt  <= '0;
            kRdy  <= 1'b0;
            kOvr  <= 1'b0;
            sRdy  <= 1'b0;
            sOvr  <= 1'b0;
        end else begin
            live  <= 1'b1;
            ks1   <= KEY;
            ks2   <= ks1;
            ss1   <= SW;
            ss2   <= ss1;
            kData <= ks2;
            if (!sDiff || sChg) dcnt <= '0;
            else dcnt <= dcnt + 1'b1;
            if (sChg) sData <= ss2;
            {kRdy, kOvr} <= nextFlags(kRdy, kOvr, kChg, kRd, kClr);
            {sRdy, sOvr} <= nextFlags(sRdy, sOvr, sChg, sRd, sClr);
        end
    end

endmodule

// File: tb/tb_io_input_responder.sv
// Bench for io_input_responder: directed corner sequences, a decode
// vector table, then random traffic against a history-based model.
module tb_io_input_responder;

    localparam int DEB = 10;
    localparam logic [31:0] AKD = 32'hF0000010;
    localparam logic [31:0] ASD = 32'hF0000014;
    localparam logic [31:0] AKC = 32'hF0000110;
    localparam logic [31:0] ASC = 32'hF0000114;

    logic        clk = 1'b0;
    logic        reset, rdEn, wrEn, rdHit;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] addr, wrData, rdData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_input_responder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .SW(SW),
        .addr(addr), .rdEn(rdEn), .wrEn(wrEn), .wrData(wrData),
        .rdHit(rdHit), .rdData(rdData)
    );

    // Model: registers derived from sample histories.
    logic [3:0] kq[$];
    logic [9:0] sq[$];
    logic [9:0] win[$];
    logic [3:0] mKd;
    logic [9:0] mSd;
    logic mKr, mKo, mSr, mSo, mLive;

    task automatic upd(inout logic r, inout logic o,
                       input logic c, input logic rd, input logic clr);
        if (clr) o = 1'b0;
        if (c) begin
            if (!r) r = 1'b1;
            else if (!rd) o = 1'b1;
        end else if (rd) begin
            r = 1'b0;
        end
    endtask

    always @(posedge clk) begin : model
        logic [3:0] k2;
        logic [9:0] s2;
        logic kRd, sRd, kClr, sClr, sChg;
        if (reset) begin
            kq.delete();
            sq.delete();
            win.delete();
            mKd = '0; mSd = '0;
            mKr = 0; mKo = 0; mSr = 0; mSo = 0;
            mLive = 0;
        end else begin
            k2 = (kq.size() == 2) ? kq[0] : 4'd0;
            s2 = (sq.size() == 2) ? sq[0] : 10'd0;
            kq.push_back(KEY);
            if (kq.size() > 2) void'(kq.pop_front());
            sq.push_back(SW);
            if (sq.size() > 2) void'(sq.pop_front());
            win.push_back(s2);
            if (win.size() > DEB) void'(win.pop_front());
            sChg = (win.size() == DEB);
            foreach (win[i]) if (win[i] == mSd) sChg = 1'b0;
            kRd  = mLive && rdEn && addr == AKD;
            sRd  = mLive && rdEn && addr == ASD;
            kClr = mLive && wrEn && addr == AKC && !wrData[2];
            sClr = mLive && wrEn && addr == ASC && !wrData[2];
            upd(mKr, mKo, k2 != mKd, kRd, kClr);
            upd(mSr, mSo, sChg, sRd, sClr);
            mKd = k2;
            if (sChg) mSd = s2;
            mLive = 1'b1;
        end
    end

    function automatic void mRead(input logic [31:0] a,
                                  output logic h, output logic [31:0] d);
        h = mLive && !reset && rdEn && (a inside {AKD, ASD, AKC, ASC});
        d = '0;
        if (h) begin
            if (a == AKD) d = {28'd0, mKd};
            if (a == ASD) d = {22'd0, mSd};
            if (a == AKC) d = {29'd0, mKo, 1'b0, mKr};
            if (a == ASC) d = {29'd0, mSo, 1'b0, mSr};
        end
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rdEn = 0;
        wrEn = 0;
        repeat (n) step();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input string n);
        addr = a; rdEn = 1; wrEn = 0;
        #1;
        chk({n, "_hit"}, 32'(rdHit), 32'd1);
        chk(n, rdData, e);
        step();
        rdEn = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wrData = d; wrEn = 1; rdEn = 0;
        step();
        wrEn = 0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic        eh;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] addrs[6] = '{AKD, ASD, AKC, ASC,
                              32'hF0000118, 32'h00000010};

    initial begin
        logic        eh;
        logic [31:0] ed;
        int r;

        tbl.push_back('{AKD, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3});
        tbl.push_back('{ASD, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3FF});
        tbl.push_back('{AKC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{ASC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{32'hF0000118, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{32'hF0000000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{32'h00000010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{32'h70000014, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{ASD, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{ASD, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3FF});
        tbl.push_back('{AKD, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0});
        tbl.push_back('{AKD, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3});
        tbl.push_back('{AKC, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0});

        reset = 1; KEY = 0; SW = 0;
        rdEn = 0; wrEn = 0; addr = 0; wrData = 0;
        step();
        step();
        addr = AKD; rdEn = 1;
        #1;
        chk("rst_hit", 32'(rdHit), 32'd0);
        chk("rst_data", rdData, 32'd0);
        step();

        // First cycle after reset: bus held off.
        reset = 0; KEY = 4'hF; addr = AKC;
        #1;
        chk("dead_hit", 32'(rdHit), 32'd0);
        step();
        rd(AKD, 32'h0, "kd_lat1");
        rd(AKD, 32'h0, "kd_lat2");
        rd(AKC, 32'h1, "kctrl_rdy");
        rd(AKD, 32'hF, "kd_val");
        rd(AKC, 32'h0, "kctrl_clr");

        KEY = 4'h5;
        step();
        KEY = 4'hA;
        idle(4);
        rd(AKC, 32'h5, "kctrl_ovr");
        wr(AKC, 32'h0);
        rd(AKC, 32'h1, "kctrl_wr0");
        wr(AKC, 32'h4);
        rd(AKC, 32'h1, "kctrl_wr4");

        // KDATA update coinciding with a KDATA read.
        KEY = 4'h3;
        step();
        step();
        rd(AKD, 32'hA, "kd_same_edge");
        rd(AKC, 32'h1, "kctrl_same_edge");
        rd(AKD, 32'h3, "kd_new");

        for (int i = 0; i < 30; i++) begin
            SW = (i % 5 == 4) ? 10'h000 : 10'h3FF;
            step();
        end
        SW = 10'h3FF;
        rd(ASD, 32'h0, "sd_glitch");
        idle(10);
        rd(ASD, 32'h0, "sd_deb_pre");
        rd(ASC, 32'h1, "sctrl_rdy");
        rd(ASD, 32'h3FF, "sd_deb_val");

        foreach (tbl[i]) begin
            addr = tbl[i].a; rdEn = tbl[i].rd;
            wrEn = tbl[i].wr; wrData = tbl[i].wd;
            #1;
            chk($sformatf("tbl%0d_hit", i), 32'(rdHit), 32'(tbl[i].eh));
            chk($sformatf("tbl%0d_data", i), rdData, tbl[i].ed);
            step();
        end
        idle(1);

        // Reset in the middle of a debounce with overrun pending.
        SW = 10'h000;
        idle(14);
        SW = 10'h155;
        idle(14);
        rd(ASC, 32'h5, "sctrl_ovr");
        SW = 10'h2AA;
        step();
        idle(8);
        chk("dcnt7", 32'(dut.dcnt), 32'd7);
        reset = 1; addr = ASC; rdEn = 1;
        #1;
        chk("rst_mid_hit", 32'(rdHit), 32'd0);
        step();
        reset = 0;
        #1;
        chk("dcnt_rst", 32'(dut.dcnt), 32'd0);
        chk("dead2_hit", 32'(rdHit), 32'd0);
        chk("dead2_data", rdData, 32'd0);
        step();
        rd(ASC, 32'h0, "sctrl_rst");
        rd(ASD, 32'h0, "sd_rst");

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) KEY = 4'($urandom);
            r = $urandom_range(31);
            if (r == 0) SW = 10'($urandom);
            else if (r == 1) SW = SW ^ 10'(1 << $urandom_range(9));
            addr = addrs[$urandom_range(5)];
            rdEn = 1'($urandom_range(1));
            wrEn = ($urandom_range(3) == 0);
            wrData = $urandom;
            #1;
            mRead(addr, eh, ed);
            chk("rnd_hit", 32'(rdHit), 32'(eh));
            chk("rnd_data", rdData, ed);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
